mod_inv_256: RTL

Iterative modular-inverse unit for the GF(P) datapath: computes out = a⁻¹ mod P using the binary extended Euclidean algorithm, one micro-step per clock. It is the division counterpart of the multi-cycle multiplier/mod_256 chain. The ECC control FSM uses it for affine conversion and point-formula divisions. It uses the same start/valid pulse protocol as the multiplier.

---
 rtl/mod_inv_256.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mod_inv_256.sv
// Iterative GF(P) modular inverse, binary extended Euclid, one step per clock.
// Optional MODINV_CONST_TIME_EN pads every operation to a fixed latency.
module mod_inv_256 #(
    parameter int unsigned      BW_GF    = 256,
    parameter logic [BW_GF-1:0] P        =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
    parameter int unsigned      MAX_ITER = 4*BW_GF+4
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             start,
    input  logic [BW_GF-1:0] a,
    output logic [BW_GF-1:0] out,
    output logic             valid,
    output logic             err,
    output logic             busy
);

    localparam int unsigned IW = $clog2(MAX_ITER);
    localparam logic [IW-1:0] ITER_LAST = IW'(MAX_ITER - 1);
    localparam logic [BW_GF-1:0] ONE = BW_GF'(1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RUN,
`ifdef MODINV_CONST_TIME_EN
        PAD,
`endif
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [BW_GF-1:0] a_q, a_d;
    logic [BW_GF-1:0] u_q, u_d, v_q, v_d;
    logic [BW_GF-1:0] x1_q, x1_d, x2_q, x2_d;
    logic [BW_GF-1:0] res_q, res_d;
    logic [BW_GF-1:0] out_q;
    logic [IW-1:0]    iter_q, iter_d;
    logic             err_q, err_d;
    logic             fin;

    // x/2 mod P: odd values get P added first, using one extra bit
    function automatic logic [BW_GF-1:0] half_mod(input logic [BW_GF-1:0] x);
        logic [BW_GF:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, P}) : {1'b0, x};
        return s[BW_GF:1];
    endfunction

    function automatic logic [BW_GF-1:0] sub_mod(input logic [BW_GF-1:0] x,
                                                 input logic [BW_GF-1:0] y);
        logic [BW_GF:0] d;
        d = {1'b0, x} - {1'b0, y};
        return d[BW_GF] ? (d[BW_GF-1:0] + P) : d[BW_GF-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        iter_d  = iter_q;
        res_d   = res_q;
        err_d   = err_q;
        fin     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    res_d   = '0;
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                iter_d = '0;
                if (a_q == '0 || a_q >= P) begin
                    err_d = 1'b1;
                    fin   = 1'b1;
                end else begin
                    u_d     = a_q;
                    v_d     = P;
                    x1_d    = ONE;
                    x2_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                iter_d = iter_q + IW'(1);
                if (u_q == ONE) begin
                    res_d = x1_q;
                    fin   = 1'b1;
                end else if (v_q == ONE) begin
                    res_d = x2_q;
                    fin   = 1'b1;
                end else if (u_q == '0 || v_q == '0 || iter_q == ITER_LAST) begin
                    err_d = 1'b1;
                    fin   = 1'b1;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = half_mod(x1_q);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = half_mod(x2_q);
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = sub_mod(x1_q, x2_q);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = sub_mod(x2_q, x1_q);
                end
            end
`ifdef MODINV_CONST_TIME_EN
            PAD: begin
                iter_d = iter_q + IW'(1);
                if (iter_q == ITER_LAST) state_d = DONE;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fin) begin
`ifdef MODINV_CONST_TIME_EN
            // an exit on the last budgeted cycle has no room left to pad
            state_d = (state_q == RUN && iter_q == ITER_LAST) ? DONE : PAD;
`else
            state_d = DONE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            iter_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            iter_q  <= iter_d;
            res_q   <= res_d;
            err_q   <= err_d;
            if (state_d == DONE) out_q <= err_d ? '0 : res_d;
        end
    end

    assign out   = out_q;
    assign valid = (state_q == DONE);
    assign err   = (state_q == DONE) && err_q;
    assign busy  = (state_q != IDLE);

endmodule
